// File: rtl/sub_chan_pkg.sv
// -----------------------------------------------------------------------------
// sub_chan_pkg
// Shared width helpers for the multi-channel status collector (sub_chan_arb)
// and its per-channel FIFO (sub_chan_fifo).
// Contents:
//   clog2_min1(n)     : ceil(log2(n)), never less than 1 (safe for n <= 2)
//   ptr_width(depth)  : FIFO read/write pointer width
//   level_width(depth): FIFO occupancy width, able to hold 0..depth
//   DEF_*             : default parameter values and their derived widths
// -----------------------------------------------------------------------------
package sub_chan_pkg;

  localparam int DEF_NCHAN = 4;
  localparam int DEF_DW    = 4;
  localparam int DEF_DEPTH = 4;

  // Width of an index selecting among n items. Widths of zero are
  // never useful as vector ranges, so the result is clamped to 1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pointers address DEPTH entries and wrap naturally modulo DEPTH
  // because DEPTH is a power of two.
  function automatic int ptr_width(input int depth);
    return clog2_min1(depth);
  endfunction

  // One extra bit over the pointer so a full FIFO (level == depth)
  // is distinguishable from an empty one.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_PTR_W   = ptr_width(DEF_DEPTH);
  localparam int DEF_LEVEL_W = level_width(DEF_DEPTH);
  localparam int DEF_CHAN_W  = clog2_min1(DEF_NCHAN);

endpackage

// File: rtl/sub_chan_fifo.sv
// -----------------------------------------------------------------------------
// sub_chan_fifo
// Small synchronous FIFO buffering one channel of the status collector.
// The caller qualifies push/pop: push only when level != DEPTH, pop only
// when level != 0. Flush discards contents and any push/pop that cycle.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   flush      : synchronous clear of pointers and level
//   push, wdata: write strobe and data
//   pop        : advance the read pointer past the head entry
//   rdata      : head entry, combinational
//   level      : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sub_chan_fifo
  import sub_chan_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = ptr_width(DEPTH),
  localparam int LW    = level_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage array: no reset needed, since entries are only ever read
  // after being written and level/pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping. A simultaneous push and pop
  // leaves level unchanged while both pointers advance, preserving order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sub_chan_arb.sv
// -----------------------------------------------------------------------------
// sub_chan_arb
// Collects NCHAN independent status streams, buffers each in its own FIFO
// and merges them round-robin onto one registered valid/ready output that
// is tagged with the source channel.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   flush      : synchronous clear of all FIFOs and the output register
//   in_valid   : per-channel write request           [NCHAN]
//   in_data    : channel c at bits [c*DW +: DW]      [NCHAN*DW]
//   in_ready   : per-channel space available         [NCHAN]
//   out_valid  : output word present
//   out_ready  : consumer accepts
//   out_data   : merged data                         [DW]
//   out_chan   : source channel of out_data          [clog2(NCHAN)]
//   level      : per-channel occupancy, 0..DEPTH     [NCHAN*LW]
// -----------------------------------------------------------------------------
module sub_chan_arb
  import sub_chan_pkg::*;
#(
  parameter  int NCHAN = DEF_NCHAN,
  parameter  int DW    = DEF_DW,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = clog2_min1(NCHAN),
  localparam int LW    = level_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [NCHAN-1:0]    in_valid,
  input  logic [NCHAN*DW-1:0] in_data,
  output logic [NCHAN-1:0]    in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [CW-1:0]       out_chan,
  output logic [NCHAN*LW-1:0] level
);

  logic [DW-1:0]    fifo_rdata [NCHAN];
  logic [LW-1:0]    fifo_level [NCHAN];
  logic [NCHAN-1:0] non_empty;
  logic [NCHAN-1:0] push;
  logic [NCHAN-1:0] pop;
  logic [CW-1:0]    rr_last;
  logic [CW-1:0]    grant_idx;
  logic             grant_valid;
  logic             load;

  // One FIFO per channel. in_ready depends only on registered level, so a
  // full FIFO refuses a push even if it is being popped this cycle.
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign in_ready[c]         = (fifo_level[c] != LW'(DEPTH));
    assign non_empty[c]        = (fifo_level[c] != '0);
    assign push[c]             = in_valid[c] && in_ready[c] && !flush;
    assign level[c*LW +: LW]   = fifo_level[c];

    sub_chan_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push[c]),
      .wdata (in_data[c*DW +: DW]),
      .pop   (pop[c]),
      .rdata (fifo_rdata[c]),
      .level (fifo_level[c])
    );
  end

  assign load = !out_valid || out_ready;

  // Rotate-mask priority encoder. The first loop finds the lowest
  // non-empty channel overall (the wrap-around choice); the second loop
  // overrides it with the lowest non-empty channel strictly above
  // rr_last when one exists. Both loops run high-to-low so the lowest
  // matching index is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int c = NCHAN - 1; c >= 0; c--) begin
      if (non_empty[c]) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(c);
      end
    end
    for (int c = NCHAN - 1; c >= 0; c--) begin
      if (non_empty[c] && (CW'(c) > rr_last)) begin
        grant_idx = CW'(c);
      end
    end
  end

  // Pop exactly the granted channel whenever the output register loads.
  always_comb begin
    pop = '0;
    for (int c = 0; c < NCHAN; c++) begin
      pop[c] = load && grant_valid && (grant_idx == CW'(c)) && !flush;
    end
  end

  // Output register and round-robin pointer. With nothing to send on a
  // load, only out_valid drops; data and channel keep their old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_last   <= CW'(NCHAN - 1);
    end else if (flush) begin
      out_valid <= 1'b0;
      rr_last   <= CW'(NCHAN - 1);
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= fifo_rdata[grant_idx];
        out_chan  <= grant_idx;
        rr_last   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
